// File: rtl/ysyx_25040129_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040129_axi_pkg
//  Description : Shared types and constants for the MMU-side AXI arbiter:
//                arbiter FSM states, master identifiers and AXI response codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_25040129_axi_pkg;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_e;

    // Upstream master identifiers
    typedef enum logic {
        MID_IFU = 1'b0,
        MID_LSU = 1'b1
    } mid_e;

    // AXI response codes
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ysyx_25040129_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040129_rr_pick
//  Description : Two-way round-robin read picker.
//                req[0] = IFU request, req[1] = LSU request.
//                last   = master that won the previous read grant.
//                grant  = chosen master; when both request, the one that did
//                         not win last time. With no request the output is
//                         MID_IFU and is ignored by the caller.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040129_rr_pick
    import ysyx_25040129_axi_pkg::*;
(
    input  logic [1:0] req,
    input  mid_e       last,
    output mid_e       grant
);

    always_comb begin
        grant = MID_IFU;
        if (req == 2'b11) begin
            grant = (last == MID_IFU) ? MID_LSU : MID_IFU;
        end else if (req[1]) begin
            grant = MID_LSU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_25040129_mmu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040129_mmu_arbiter
//  Description : Shares the single MMU-side AXI4 port between the IFU
//                (read-only) and the LSU (read + write). One transaction in
//                flight at a time; the granted access is stamped with the
//                satp value sampled at grant. LSU writes (AW and W both
//                valid) beat any read; reads use round-robin (RR_EN=1) or
//                fixed LSU-over-IFU priority (RR_EN=0).
//  Ports       : clk/rst (async, active-low), csr_satp,
//                ifu_ar*/ifu_r*  - IFU read channel (slave side)
//                lsu_ar*/lsu_r*/lsu_aw*/lsu_w*/lsu_b* - LSU channels
//                m_ar*/m_r*/m_aw*/m_w*/m_b* - towards the MMU
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040129_mmu_arbiter
    import ysyx_25040129_axi_pkg::*;
#(
    parameter int unsigned RR_EN = 1,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] csr_satp,
    // IFU read
    input  logic [AW-1:0] ifu_araddr,
    input  logic [2:0]    ifu_arsize,
    input  logic [7:0]    ifu_arlen,
    input  logic [1:0]    ifu_arburst,
    input  logic          ifu_arvalid,
    output logic          ifu_arready,
    output logic [AW-1:0] ifu_rdata,
    output logic [1:0]    ifu_rresp,
    output logic          ifu_rlast,
    output logic          ifu_rvalid,
    input  logic          ifu_rready,
    // LSU read
    input  logic [AW-1:0] lsu_araddr,
    input  logic [2:0]    lsu_arsize,
    input  logic [7:0]    lsu_arlen,
    input  logic [1:0]    lsu_arburst,
    input  logic          lsu_arvalid,
    output logic          lsu_arready,
    output logic [AW-1:0] lsu_rdata,
    output logic [1:0]    lsu_rresp,
    output logic          lsu_rlast,
    output logic          lsu_rvalid,
    input  logic          lsu_rready,
    // LSU write
    input  logic [AW-1:0] lsu_awaddr,
    input  logic          lsu_awvalid,
    output logic          lsu_awready,
    input  logic [AW-1:0] lsu_wdata,
    input  logic [3:0]    lsu_wstrb,
    input  logic          lsu_wvalid,
    output logic          lsu_wready,
    output logic [1:0]    lsu_bresp,
    output logic          lsu_bvalid,
    input  logic          lsu_bready,
    // MMU side
    output logic [AW-1:0] m_araddr,
    output logic [2:0]    m_arsize,
    output logic [7:0]    m_arlen,
    output logic [1:0]    m_arburst,
    output logic          m_arvalid,
    output logic [AW-1:0] m_arsatp,
    input  logic          m_arready,
    input  logic [AW-1:0] m_rdata,
    input  logic [1:0]    m_rresp,
    input  logic          m_rlast,
    input  logic          m_rvalid,
    output logic          m_rready,
    output logic [AW-1:0] m_awaddr,
    output logic          m_awvalid,
    output logic [AW-1:0] m_awsatp,
    input  logic          m_awready,
    output logic [AW-1:0] m_wdata,
    output logic [3:0]    m_wstrb,
    output logic          m_wvalid,
    input  logic          m_wready,
    input  logic [1:0]    m_bresp,
    input  logic          m_bvalid,
    output logic          m_bready
);

    state_e        r_state_q, w_state_d;
    mid_e          r_gid_q,   w_gid_d;    // master owning the current transaction
    mid_e          r_last_q,  w_last_d;   // winner of the most recent read address handshake
    logic [AW-1:0] r_satp_q,  w_satp_d;
    logic          r_aw_done_q, w_aw_done_d;
    logic          r_w_done_q,  w_w_done_d;

    mid_e w_rr_grant;
    mid_e w_fix_grant;
    mid_e w_rd_pick;

    ysyx_25040129_rr_pick u_rr_pick (
        .req   ({lsu_arvalid, ifu_arvalid}),
        .last  (r_last_q),
        .grant (w_rr_grant)
    );

    assign w_fix_grant = lsu_arvalid ? MID_LSU : MID_IFU;
    assign w_rd_pick   = (RR_EN != 0) ? w_rr_grant : w_fix_grant;

    logic w_rd_addr, w_rd_data, w_wr_req, w_wr_resp, w_sel_lsu;
    assign w_rd_addr = (r_state_q == ST_RD_ADDR);
    assign w_rd_data = (r_state_q == ST_RD_DATA);
    assign w_wr_req  = (r_state_q == ST_WR_REQ);
    assign w_wr_resp = (r_state_q == ST_WR_RESP);
    assign w_sel_lsu = (r_gid_q == MID_LSU);

    logic w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;
    assign w_aw_hs  = m_awvalid & m_awready;
    assign w_w_hs   = m_wvalid & m_wready;
    assign w_aw_fin = r_aw_done_q | w_aw_hs;
    assign w_w_fin  = r_w_done_q | w_w_hs;

    always_comb begin
        w_state_d   = r_state_q;
        w_gid_d     = r_gid_q;
        w_last_d    = r_last_q;
        w_satp_d    = r_satp_q;
        w_aw_done_d = r_aw_done_q;
        w_w_done_d  = r_w_done_q;
        case (r_state_q)
            ST_IDLE: begin
                // A write needs both AW and W present before it can be passed on
                if (lsu_awvalid && lsu_wvalid) begin
                    w_state_d = ST_WR_REQ;
                    w_gid_d   = MID_LSU;
                    w_satp_d  = csr_satp;
                end else if (ifu_arvalid || lsu_arvalid) begin
                    w_state_d = ST_RD_ADDR;
                    w_gid_d   = w_rd_pick;
                    w_satp_d  = csr_satp;
                end
            end
            ST_RD_ADDR: begin
                if (m_arvalid && m_arready) begin
                    w_state_d = ST_RD_DATA;
                    w_last_d  = r_gid_q;
                end
            end
            ST_RD_DATA: begin
                if (m_rvalid && m_rready && m_rlast) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (w_aw_fin && w_w_fin) begin
                    w_state_d   = ST_WR_RESP;
                    w_aw_done_d = 1'b0;
                    w_w_done_d  = 1'b0;
                end else begin
                    w_aw_done_d = w_aw_fin;
                    w_w_done_d  = w_w_fin;
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid && m_bready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q   <= ST_IDLE;
            r_gid_q     <= MID_IFU;
            r_last_q    <= MID_IFU;
            r_satp_q    <= '0;
            r_aw_done_q <= 1'b0;
            r_w_done_q  <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_gid_q     <= w_gid_d;
            r_last_q    <= w_last_d;
            r_satp_q    <= w_satp_d;
            r_aw_done_q <= w_aw_done_d;
            r_w_done_q  <= w_w_done_d;
        end
    end

    // Read address: granted master's request forwarded while in RD_ADDR only
    assign m_arvalid   = w_rd_addr;
    assign m_araddr    = w_rd_addr ? (w_sel_lsu ? lsu_araddr  : ifu_araddr)  : '0;
    assign m_arsize    = w_rd_addr ? (w_sel_lsu ? lsu_arsize  : ifu_arsize)  : '0;
    assign m_arlen     = w_rd_addr ? (w_sel_lsu ? lsu_arlen   : ifu_arlen)   : '0;
    assign m_arburst   = w_rd_addr ? (w_sel_lsu ? lsu_arburst : ifu_arburst) : '0;
    assign m_arsatp    = w_rd_addr ? r_satp_q : '0;
    assign ifu_arready = w_rd_addr & ~w_sel_lsu & m_arready;
    assign lsu_arready = w_rd_addr &  w_sel_lsu & m_arready;

    // Read data: routed to the granted master; the other one sees nothing
    assign m_rready   = w_rd_data & (w_sel_lsu ? lsu_rready : ifu_rready);
    assign ifu_rvalid = w_rd_data & ~w_sel_lsu & m_rvalid;
    assign ifu_rdata  = (w_rd_data & ~w_sel_lsu) ? m_rdata : '0;
    assign ifu_rresp  = (w_rd_data & ~w_sel_lsu) ? m_rresp : '0;
    assign ifu_rlast  = w_rd_data & ~w_sel_lsu & m_rlast;
    assign lsu_rvalid = w_rd_data & w_sel_lsu & m_rvalid;
    assign lsu_rdata  = (w_rd_data & w_sel_lsu) ? m_rdata : '0;
    assign lsu_rresp  = (w_rd_data & w_sel_lsu) ? m_rresp : '0;
    assign lsu_rlast  = w_rd_data & w_sel_lsu & m_rlast;

    // Write request: each valid drops once its own handshake is done
    assign m_awvalid   = w_wr_req & ~r_aw_done_q;
    assign m_awaddr    = w_wr_req ? lsu_awaddr : '0;
    assign m_awsatp    = w_wr_req ? r_satp_q : '0;
    assign lsu_awready = m_awvalid & m_awready;
    assign m_wvalid    = w_wr_req & ~r_w_done_q;
    assign m_wdata     = w_wr_req ? lsu_wdata : '0;
    assign m_wstrb     = w_wr_req ? lsu_wstrb : '0;
    assign lsu_wready  = m_wvalid & m_wready;

    // Write response
    assign lsu_bvalid = w_wr_resp & m_bvalid;
    assign lsu_bresp  = w_wr_resp ? m_bresp : '0;
    assign m_bready   = w_wr_resp & lsu_bready;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040129_mmu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_25040129_mmu_arbiter
//  Description : Self-checking bench for the MMU arbiter. The main instance
//                uses round-robin reads; a second fixed-priority instance
//                shares all inputs and is checked where the two policies
//                diverge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040129_mmu_arbiter;
    import ysyx_25040129_axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [31:0] csr_satp;
    logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, m_rdata;
    logic [2:0]  ifu_arsize, lsu_arsize;
    logic [7:0]  ifu_arlen, lsu_arlen;
    logic [1:0]  ifu_arburst, lsu_arburst, m_rresp, m_bresp;
    logic [3:0]  lsu_wstrb;
    logic ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready;
    logic m_arready, m_rlast, m_rvalid, m_awready, m_wready, m_bvalid;

    logic ifu_arready, ifu_rlast, ifu_rvalid, lsu_arready, lsu_rlast, lsu_rvalid;
    logic lsu_awready, lsu_wready, lsu_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [31:0] ifu_rdata, lsu_rdata, m_araddr, m_arsatp, m_awaddr, m_awsatp, m_wdata;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp, m_arburst;
    logic [2:0]  m_arsize;
    logic [7:0]  m_arlen;
    logic [3:0]  m_wstrb;

    logic fx_ifu_arready, fx_ifu_rlast, fx_ifu_rvalid, fx_lsu_arready, fx_lsu_rlast, fx_lsu_rvalid;
    logic fx_lsu_awready, fx_lsu_wready, fx_lsu_bvalid, fx_m_arvalid, fx_m_rready;
    logic fx_m_awvalid, fx_m_wvalid, fx_m_bready;
    logic [31:0] fx_ifu_rdata, fx_lsu_rdata, fx_m_araddr, fx_m_arsatp, fx_m_awaddr, fx_m_awsatp, fx_m_wdata;
    logic [1:0]  fx_ifu_rresp, fx_lsu_rresp, fx_lsu_bresp, fx_m_arburst;
    logic [2:0]  fx_m_arsize;
    logic [7:0]  fx_m_arlen;
    logic [3:0]  fx_m_wstrb;

    ysyx_25040129_mmu_arbiter #(.RR_EN(1), .AW(32)) dut (
        .clk(clk), .rst(rst), .csr_satp(csr_satp),
        .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arlen(ifu_arlen),
        .ifu_arburst(ifu_arburst), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arlen(lsu_arlen),
        .lsu_arburst(lsu_arburst), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
        .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
        .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arsatp(m_arsatp), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .m_awaddr(m_awaddr), .m_awvalid(m_awvalid),
        .m_awsatp(m_awsatp), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready)
    );

    ysyx_25040129_mmu_arbiter #(.RR_EN(0), .AW(32)) dut_fx (
        .clk(clk), .rst(rst), .csr_satp(csr_satp),
        .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arlen(ifu_arlen),
        .ifu_arburst(ifu_arburst), .ifu_arvalid(ifu_arvalid), .ifu_arready(fx_ifu_arready),
        .ifu_rdata(fx_ifu_rdata), .ifu_rresp(fx_ifu_rresp), .ifu_rlast(fx_ifu_rlast),
        .ifu_rvalid(fx_ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arlen(lsu_arlen),
        .lsu_arburst(lsu_arburst), .lsu_arvalid(lsu_arvalid), .lsu_arready(fx_lsu_arready),
        .lsu_rdata(fx_lsu_rdata), .lsu_rresp(fx_lsu_rresp), .lsu_rlast(fx_lsu_rlast),
        .lsu_rvalid(fx_lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(fx_lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
        .lsu_wready(fx_lsu_wready), .lsu_bresp(fx_lsu_bresp), .lsu_bvalid(fx_lsu_bvalid),
        .lsu_bready(lsu_bready),
        .m_araddr(fx_m_araddr), .m_arsize(fx_m_arsize), .m_arlen(fx_m_arlen),
        .m_arburst(fx_m_arburst), .m_arvalid(fx_m_arvalid), .m_arsatp(fx_m_arsatp),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(fx_m_rready), .m_awaddr(fx_m_awaddr),
        .m_awvalid(fx_m_awvalid), .m_awsatp(fx_m_awsatp), .m_awready(m_awready),
        .m_wdata(fx_m_wdata), .m_wstrb(fx_m_wstrb), .m_wvalid(fx_m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(fx_m_bready)
    );

    int n_cmp = 0;
    int n_err = 0;
    int last_id;   // reference model: 0 = IFU, 1 = LSU won the last read

    // Which master the arbiter must serve among pending reads
    function automatic int model_pick(input bit ifu, input bit lsu, input bit rr, input int last);
        if (ifu && lsu) return rr ? (1 - last) : 1;
        return lsu ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Serve one read from the MMU side; requests are already being driven.
    task automatic do_read(input string tag, input int exp_id, input logic [7:0] exp_len,
                           input logic [1:0] resp, input bit keep,
                           input bit chk_fx, input logic [31:0] fx_addr);
        logic [31:0] satp_snap, exp_addr, dat;
        int n;
        bit seen;
        satp_snap = csr_satp;
        exp_addr  = (exp_id == 1) ? lsu_araddr : ifu_araddr;
        n = 0;
        seen = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (m_arvalid) begin
                seen = 1'b1;
                break;
            end
            step();
            n++;
        end
        chk({tag, "_ar_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        chk({tag, "_ar_lat"}, n, 1);
        chk({tag, "_araddr"}, m_araddr, exp_addr);
        chk({tag, "_arlen"}, 32'(m_arlen), 32'(exp_len));
        if (chk_fx) chk({tag, "_fx_araddr"}, fx_m_araddr, fx_addr);
        // satp moves while the request is stalled; the stamped value must not
        csr_satp = ~satp_snap;
        m_arready = 1'b0;
        #1;
        chk({tag, "_arsatp"}, m_arsatp, satp_snap);
        step();
        chk({tag, "_ar_hold"}, 32'(m_arvalid), 32'd1);
        chk({tag, "_arsatp_hold"}, m_arsatp, satp_snap);
        m_arready = 1'b1;
        #1;
        chk({tag, "_arready_own"}, 32'((exp_id == 1) ? lsu_arready : ifu_arready), 32'd1);
        chk({tag, "_arready_other"}, 32'((exp_id == 1) ? ifu_arready : lsu_arready), 32'd0);
        step();
        m_arready = 1'b0;
        if (!keep) begin
            if (exp_id == 1) lsu_arvalid = 1'b0;
            else             ifu_arvalid = 1'b0;
        end
        last_id = exp_id;
        for (int b = 0; b <= int'(exp_len); b++) begin
            dat = $urandom;
            m_rdata  = dat;
            m_rresp  = resp;
            m_rlast  = (b == int'(exp_len));
            m_rvalid = 1'b1;
            #1;
            chk({tag, "_rvalid_own"}, 32'((exp_id == 1) ? lsu_rvalid : ifu_rvalid), 32'd1);
            chk({tag, "_rvalid_other"}, 32'((exp_id == 1) ? ifu_rvalid : lsu_rvalid), 32'd0);
            chk({tag, "_rdata"}, (exp_id == 1) ? lsu_rdata : ifu_rdata, dat);
            chk({tag, "_rresp"}, 32'((exp_id == 1) ? lsu_rresp : ifu_rresp), 32'(resp));
            chk({tag, "_rlast"}, 32'((exp_id == 1) ? lsu_rlast : ifu_rlast), 32'(b == int'(exp_len)));
            step();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    // Serve one LSU write: AW accepted a cycle before W, then OKAY response
    task automatic do_write(input string tag);
        logic [31:0] satp_snap;
        int n;
        bit seen;
        satp_snap = csr_satp;
        n = 0;
        seen = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (m_awvalid) begin
                seen = 1'b1;
                break;
            end
            step();
            n++;
        end
        chk({tag, "_aw_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        chk({tag, "_aw_lat"}, n, 1);
        chk({tag, "_awaddr"}, m_awaddr, lsu_awaddr);
        chk({tag, "_wdata"}, m_wdata, lsu_wdata);
        chk({tag, "_wstrb"}, 32'(m_wstrb), 32'(lsu_wstrb));
        chk({tag, "_wvalid"}, 32'(m_wvalid), 32'd1);
        chk({tag, "_no_ar"}, 32'(m_arvalid), 32'd0);
        csr_satp  = ~satp_snap;
        m_awready = 1'b1;
        m_wready  = 1'b0;
        #1;
        chk({tag, "_awsatp"}, m_awsatp, satp_snap);
        chk({tag, "_awready"}, 32'(lsu_awready), 32'd1);
        chk({tag, "_wready_early"}, 32'(lsu_wready), 32'd0);
        chk({tag, "_ifu_arready"}, 32'(ifu_arready), 32'd0);
        step();
        lsu_awvalid = 1'b0;
        m_wready    = 1'b1;
        #1;
        chk({tag, "_aw_dropped"}, 32'(m_awvalid), 32'd0);
        chk({tag, "_w_held"}, 32'(m_wvalid), 32'd1);
        chk({tag, "_wready"}, 32'(lsu_wready), 32'd1);
        step();
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        lsu_wvalid = 1'b0;
        m_bresp    = c_RESP_OKAY;
        m_bvalid   = 1'b1;
        lsu_bready = 1'b1;
        #1;
        chk({tag, "_w_dropped"}, 32'(m_wvalid), 32'd0);
        chk({tag, "_bvalid"}, 32'(lsu_bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(lsu_bresp), 32'(c_RESP_OKAY));
        chk({tag, "_bready"}, 32'(m_bready), 32'd1);
        step();
        m_bvalid   = 1'b0;
        lsu_bready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        bit wi, ri, rl;
        rst = 1'b0;
        csr_satp = 32'h0;
        ifu_araddr = 32'h8000_0000; ifu_arsize = 3'd2; ifu_arlen = 8'd0; ifu_arburst = 2'b01;
        lsu_araddr = 32'h0; lsu_arsize = 3'd2; lsu_arlen = 8'd0; lsu_arburst = 2'b01;
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b0; ifu_rready = 1'b1; lsu_rready = 1'b1;
        lsu_awaddr = 32'h0; lsu_awvalid = 1'b0; lsu_wdata = 32'h0; lsu_wstrb = 4'h0;
        lsu_wvalid = 1'b0; lsu_bready = 1'b0;
        m_arready = 1'b1; m_rdata = 32'h0; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b1;
        last_id = 0;

        // Reset: outputs quiet even with live inputs
        step();
        step();
        chk("rst_arvalid", 32'(m_arvalid), 32'd0);
        chk("rst_araddr", m_araddr, 32'd0);
        chk("rst_ifu_arready", 32'(ifu_arready), 32'd0);
        chk("rst_lsu_bvalid", 32'(lsu_bvalid), 32'd0);
        chk("rst_awvalid", 32'(m_awvalid), 32'd0);
        chk("rst_wvalid", 32'(m_wvalid), 32'd0);
        ifu_arvalid = 1'b0; m_arready = 1'b0; m_bvalid = 1'b0;
        step();
        rst = 1'b1;
        step();

        // 1: lone IFU read
        csr_satp = $urandom;
        ifu_araddr = 32'h8000_0000;
        ifu_arvalid = 1'b1;
        do_read("s1", model_pick(1, 0, 1, last_id), 8'd0, c_RESP_OKAY, 1'b0, 1'b0, 32'h0);

        // 2: simultaneous reads; LSU holds a second request
        ifu_araddr = $urandom & 32'hFFFF_FFFC;
        lsu_araddr = $urandom & 32'hFFFF_FFFC;
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        e = model_pick(1, 1, 1, last_id);
        do_read("s2a", e, 8'd0, c_RESP_OKAY, 1'b1, 1'b1, lsu_araddr);
        e = model_pick(1, 1, 1, last_id);
        do_read("s2b", e, 8'd0, c_RESP_OKAY, 1'b0, 1'b1, lsu_araddr);
        e = model_pick(ifu_arvalid, lsu_arvalid, 1, last_id);
        do_read("s2c", e, 8'd0, c_RESP_OKAY, 1'b0, 1'b0, 32'h0);

        // 3: AW without W is not granted; then write beats a concurrent IFU read
        lsu_awaddr = 32'h8000_0100;
        lsu_wdata  = 32'h1234_5678;
        lsu_wstrb  = 4'hF;
        lsu_awvalid = 1'b1;
        step();
        step();
        chk("s3_aw_alone", 32'(m_awvalid), 32'd0);
        chk("s3_aw_alone_ar", 32'(m_arvalid), 32'd0);
        lsu_wvalid = 1'b1;
        ifu_araddr = $urandom & 32'hFFFF_FFFC;
        ifu_arvalid = 1'b1;
        csr_satp = $urandom;
        do_write("s3w");
        do_read("s3r", model_pick(1, 0, 1, last_id), 8'd0, c_RESP_OKAY, 1'b0, 1'b0, 32'h0);

        // 4: satp stamped at grant
        csr_satp = 32'h8008_0000;
        ifu_arvalid = 1'b1;
        do_read("s4", model_pick(1, 0, 1, last_id), 8'd0, c_RESP_OKAY, 1'b0, 1'b0, 32'h0);

        // 5: 4-beat burst with SLVERR
        lsu_araddr = $urandom & 32'hFFFF_FFFC;
        lsu_arlen = 8'd3;
        lsu_arvalid = 1'b1;
        do_read("s5", model_pick(0, 1, 1, last_id), 8'd3, c_RESP_SLVERR, 1'b0, 1'b0, 32'h0);

        // 6: reset in the middle of read data
        ifu_araddr = $urandom & 32'hFFFF_FFFC;
        ifu_arvalid = 1'b1;
        step();
        chk("s6_ar", 32'(m_arvalid), 32'd1);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        ifu_arvalid = 1'b0;
        m_rdata = $urandom;
        m_rvalid = 1'b1;
        #1;
        chk("s6_rvalid_pre", 32'(ifu_rvalid), 32'd1);
        rst = 1'b0;
        #1;
        chk("s6_rvalid_rst", 32'(ifu_rvalid), 32'd0);
        chk("s6_rready_rst", 32'(m_rready), 32'd0);
        chk("s6_arvalid_rst", 32'(m_arvalid), 32'd0);
        step();
        m_rvalid = 1'b0;
        rst = 1'b1;
        last_id = 0;
        step();
        ifu_arvalid = 1'b1;
        csr_satp = $urandom;
        do_read("s6", model_pick(1, 0, 1, last_id), 8'd0, c_RESP_OKAY, 1'b0, 1'b0, 32'h0);

        // Randomized mixes of writes and reads
        for (int k = 0; k < 16; k++) begin
            wi = ($urandom_range(0, 2) == 0);
            ri = $urandom_range(0, 1) != 0;
            rl = $urandom_range(0, 1) != 0;
            if (!wi && !ri && !rl) ri = 1'b1;
            csr_satp = $urandom;
            ifu_araddr = $urandom & 32'hFFFF_FFFC;
            lsu_araddr = $urandom & 32'hFFFF_FFFC;
            ifu_arlen = 8'($urandom_range(0, 3));
            lsu_arlen = 8'($urandom_range(0, 3));
            lsu_awaddr = $urandom & 32'hFFFF_FFFC;
            lsu_wdata = $urandom;
            lsu_wstrb = 4'($urandom);
            ifu_arvalid = ri;
            lsu_arvalid = rl;
            lsu_awvalid = wi;
            lsu_wvalid = wi;
            if (wi) do_write($sformatf("rw%0d", k));
            while (ifu_arvalid || lsu_arvalid) begin
                e = model_pick(ifu_arvalid, lsu_arvalid, 1, last_id);
                csr_satp = $urandom;
                do_read($sformatf("rr%0d", k), e, (e == 1) ? lsu_arlen : ifu_arlen,
                        2'($urandom_range(0, 3)), 1'b0, 1'b0, 32'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
